// File: rtl/floo_pkg.sv
// Shared NoC types for the eject error slave: request flit encoding, FSM states
// and the DECERR response code.
package floo_pkg;

  typedef enum logic [1:0] {
    REQ_AW   = 2'b00,
    REQ_W    = 2'b01,
    REQ_AR   = 2'b10,
    REQ_RSVD = 2'b11
  } req_type_e;

  typedef enum logic [1:0] {
    IDLE,
    W_DRAIN,
    B_SEND,
    R_SEND
  } err_slv_state_e;

  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/floo_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module floo_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + One;
    end
  end

endmodule

// File: rtl/floo_eject_err_slv.sv
// Error slave on a router Eject port: drains misrouted AXI requests and answers
// with DECERR B / R bursts. Define FLOO_ERR_SLV_STATS_EN for live statistics.
module floo_eject_err_slv
  import floo_pkg::*;
#(
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned NodeIdWidth = 6,
  parameter logic [1:0]  ErrResp     = DECERR
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_type_i,
  input  logic [IdWidth-1:0]     req_id_i,
  input  logic [7:0]             req_len_i,
  input  logic                   req_last_i,
  input  logic [NodeIdWidth-1:0] req_src_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_is_r_o,
  output logic [IdWidth-1:0]     rsp_id_o,
  output logic [NodeIdWidth-1:0] rsp_dst_o,
  output logic [1:0]             rsp_resp_o,
  output logic                   rsp_last_o,
  output logic [15:0]            stat_rd_o,
  output logic [15:0]            stat_wr_o,
  output logic [15:0]            stat_stray_o
);

  err_slv_state_e         state_q, state_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [NodeIdWidth-1:0] dst_q, dst_d;
  logic [7:0]             cnt_q, cnt_d;
  req_type_e              req_type;
  logic                   req_fire, rsp_fire;
  logic                   stray_evt, wr_done, rd_done;

  assign req_type = req_type_e'(req_type_i);

  // Ready is a function of state and flit type only; in W_DRAIN only W may pass.
  always_comb begin
    req_ready_o = 1'b0;
    case (state_q)
      IDLE:    req_ready_o = 1'b1;
      W_DRAIN: req_ready_o = (req_type == REQ_W);
      default: req_ready_o = 1'b0;
    endcase
  end

  assign req_fire    = req_valid_i & req_ready_o;
  assign rsp_valid_o = (state_q == B_SEND) || (state_q == R_SEND);
  assign rsp_fire    = rsp_valid_o & rsp_ready_i;
  assign rsp_is_r_o  = (state_q == R_SEND);
  assign rsp_last_o  = (state_q == B_SEND) || ((state_q == R_SEND) && (cnt_q == 8'd0));
  assign rsp_id_o    = rsp_valid_o ? id_q : '0;
  assign rsp_dst_o   = rsp_valid_o ? dst_q : '0;
  assign rsp_resp_o  = rsp_valid_o ? ErrResp : 2'b00;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    stray_evt = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          case (req_type)
            REQ_AW: begin
              state_d = W_DRAIN;
              id_d    = req_id_i;
              dst_d   = req_src_i;
            end
            REQ_AR: begin
              state_d = R_SEND;
              id_d    = req_id_i;
              dst_d   = req_src_i;
              cnt_d   = req_len_i;
            end
            default: stray_evt = 1'b1;
          endcase
        end
      end
      W_DRAIN: begin
        if (req_fire && req_last_i) state_d = B_SEND;
      end
      B_SEND: begin
        if (rsp_fire) begin
          state_d = IDLE;
          wr_done = 1'b1;
        end
      end
      R_SEND: begin
        // cnt holds the number of beats still to send after the current one.
        if (rsp_fire) begin
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
            rd_done = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FLOO_ERR_SLV_STATS_EN
  floo_sat_cnt #(.Width(16)) i_stat_rd (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (rd_done),
    .cnt_o (stat_rd_o)
  );

  floo_sat_cnt #(.Width(16)) i_stat_wr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (wr_done),
    .cnt_o (stat_wr_o)
  );

  floo_sat_cnt #(.Width(16)) i_stat_stray (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (stray_evt),
    .cnt_o (stat_stray_o)
  );
`else
  logic unused_evt;
  assign unused_evt   = ^{stray_evt, wr_done, rd_done};
  assign stat_rd_o    = '0;
  assign stat_wr_o    = '0;
  assign stat_stray_o = '0;
`endif

endmodule
